// File: rtl/clock_divider_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_multi_if
// Purpose  : Bundles the per-channel control and output signals of
//            clock_divider_multi.
// Signals  : enable_in   [CHANNELS]        per-channel run enable
//            mode_in     [CHANNELS]        0 = square wave, 1 = single tick
//            load_in     [CHANNELS]        divisor load strobe
//            divisor_in  [CHANNELS*WIDTH]  channel k at [k*WIDTH +: WIDTH]
//            sync_in                       phase-align strobe (only when
//                                          CLOCK_DIVIDER_PHASE_SYNC_EN)
//            clock_out   [CHANNELS]        divided output
//            tick_out    [CHANNELS]        last-count pulse
//            pending_out [CHANNELS]        loaded divisor awaiting apply
// Modports : master (drives controls), slave (the divider)
// Macro    : CLOCK_DIVIDER_PHASE_SYNC_EN adds sync_in
// Revision : 1.0 - initial release
// ============================================================================
interface clock_divider_multi_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 28
);
  logic [CHANNELS-1:0]       enable_in;
  logic [CHANNELS-1:0]       mode_in;
  logic [CHANNELS-1:0]       load_in;
  logic [CHANNELS*WIDTH-1:0] divisor_in;
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
  logic                      sync_in;
`endif
  logic [CHANNELS-1:0]       clock_out;
  logic [CHANNELS-1:0]       tick_out;
  logic [CHANNELS-1:0]       pending_out;

  modport master (
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
    output sync_in,
`endif
    output enable_in, mode_in, load_in, divisor_in,
    input  clock_out, tick_out, pending_out
  );

  modport slave (
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
    input  sync_in,
`endif
    input  enable_in, mode_in, load_in, divisor_in,
    output clock_out, tick_out, pending_out
  );
endinterface
`default_nettype wire

// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_multi
// Purpose  : Multi-channel runtime-programmable clock divider. Each channel
//            counts 0..D-1 and emits a square wave or a one-cycle tick.
//            New divisors are staged and applied only at period boundaries
//            (or immediately while the channel is disabled).
// Ports    : clock_in  - system clock, rising edge
//            reset_n   - asynchronous active-low reset
//            bus       - clock_divider_multi_if.slave (controls/outputs)
// Macro    : CLOCK_DIVIDER_PHASE_SYNC_EN adds bus.sync_in phase alignment
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_multi #(
  parameter int               CHANNELS    = 2,
  parameter int               WIDTH       = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = 28'd100000000
) (
  input  wire logic            clock_in,
  input  wire logic            reset_n,
  clock_divider_multi_if.slave bus
);

  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_TWO     = WIDTH'(2);
  localparam logic [WIDTH-1:0] C_RST_DIV = (DEFAULT_DIV < C_TWO) ? C_TWO : DEFAULT_DIV;

  logic w_sync;
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
  assign w_sync = bus.sync_in;
`else
  assign w_sync = 1'b0;
`endif

  logic [CHANNELS-1:0] w_clk_vec;
  logic [CHANNELS-1:0] w_tick_vec;
  logic [CHANNELS-1:0] w_pend_vec;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] r_cnt, r_div, r_pend_div;
    logic             r_pend, r_clk, r_tick;
    logic [WIDTH-1:0] w_slice, w_load_div, w_cnt_nxt, w_div_nxt, w_pend_div_nxt;
    logic             w_pend_nxt, w_clk_nxt, w_tick_nxt, w_en, w_apply;

    always_comb begin
      w_slice        = bus.divisor_in[k*WIDTH +: WIDTH];
      w_load_div     = (w_slice < C_TWO) ? C_TWO : w_slice;
      w_en           = bus.enable_in[k];
      // Period boundary: wrap, phase sync, or disabled (divisor may change freely)
      w_apply        = !w_en || w_sync || (r_cnt == r_div - C_ONE);
      w_cnt_nxt      = r_cnt + C_ONE;
      w_div_nxt      = r_div;
      w_pend_div_nxt = r_pend_div;
      w_pend_nxt     = r_pend;
      if (w_apply) begin
        w_cnt_nxt  = '0;
        w_pend_nxt = 1'b0;
        // A load coinciding with the boundary bypasses the staging register
        if (bus.load_in[k]) begin
          w_div_nxt = w_load_div;
        end else if (r_pend) begin
          w_div_nxt = r_pend_div;
        end
      end else if (bus.load_in[k]) begin
        w_pend_div_nxt = w_load_div;
        w_pend_nxt     = 1'b1;
      end
      // Outputs are derived from the next state so they are registered in
      // step with the counter.
      w_tick_nxt = w_en && (w_cnt_nxt == w_div_nxt - C_ONE);
      w_clk_nxt  = w_en && (bus.mode_in[k] ? w_tick_nxt
                                           : (w_cnt_nxt >= (w_div_nxt >> 1)));
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt      <= '0;
        r_div      <= C_RST_DIV;
        r_pend_div <= '0;
        r_pend     <= 1'b0;
        r_clk      <= 1'b0;
        r_tick     <= 1'b0;
      end else begin
        r_cnt      <= w_cnt_nxt;
        r_div      <= w_div_nxt;
        r_pend_div <= w_pend_div_nxt;
        r_pend     <= w_pend_nxt;
        r_clk      <= w_clk_nxt;
        r_tick     <= w_tick_nxt;
      end
    end

    assign w_clk_vec[k]  = r_clk;
    assign w_tick_vec[k] = r_tick;
    assign w_pend_vec[k] = r_pend;
  end

  assign bus.clock_out   = w_clk_vec;
  assign bus.tick_out    = w_tick_vec;
  assign bus.pending_out = w_pend_vec;

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_multi
// Purpose  : Self-checking bench for clock_divider_multi (CHANNELS=2,
//            DEFAULT_DIV=10). A behavioural model predicts each cycle's
//            outputs into a queue; entries are popped and compared after
//            the DUT clock edge.
// Macro    : CLOCK_DIVIDER_PHASE_SYNC_EN enables the phase-sync sequence
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_multi;
  localparam int CH = 2;
  localparam int W  = 28;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clock_divider_multi_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  clock_divider_multi #(
    .CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(28'd10)
  ) dut (
    .clock_in(clk), .reset_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [CH-1:0] clk_e;
    logic [CH-1:0] tick_e;
    logic [CH-1:0] pend_e;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Behavioural model state
  int   m_cnt[CH], m_d[CH], m_p[CH];
  logic m_pend[CH], m_clk[CH], m_tick[CH];

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cycle, obs, exp_v);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic void m_reset();
    for (int k = 0; k < CH; k++) begin
      m_cnt[k] = 0; m_d[k] = 10; m_p[k] = 0;
      m_pend[k] = 1'b0; m_clk[k] = 1'b0; m_tick[k] = 1'b0;
    end
  endfunction

  // Advance the model by one rising edge using the currently driven inputs.
  function automatic void m_edge();
    logic sy;
    sy = 1'b0;
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
    sy = bus.sync_in;
`endif
    for (int k = 0; k < CH; k++) begin
      int   dv;
      logic en, ld;
      dv = int'(bus.divisor_in[k*W +: W]);
      if (dv < 2) dv = 2;
      en = bus.enable_in[k];
      ld = bus.load_in[k];
      if (!en || sy || m_cnt[k] == m_d[k] - 1) begin
        if (ld) m_d[k] = dv;
        else if (m_pend[k]) m_d[k] = m_p[k];
        m_pend[k] = 1'b0;
        m_cnt[k]  = 0;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
        if (ld) begin m_p[k] = dv; m_pend[k] = 1'b1; end
      end
      m_tick[k] = en && (m_cnt[k] == m_d[k] - 1);
      m_clk[k]  = en && (bus.mode_in[k] ? m_tick[k] : (m_cnt[k] >= m_d[k] / 2));
    end
  endfunction

  function automatic exp_t m_snapshot();
    exp_t e;
    for (int k = 0; k < CH; k++) begin
      e.clk_e[k] = m_clk[k]; e.tick_e[k] = m_tick[k]; e.pend_e[k] = m_pend[k];
    end
    return e;
  endfunction

  task automatic compare_pop(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, ".clock_out"},   bus.clock_out,   e.clk_e);
    chk({tag, ".tick_out"},    bus.tick_out,    e.tick_e);
    chk({tag, ".pending_out"}, bus.pending_out, e.pend_e);
  endtask

  // One clock: predict, push, let the DUT clock, then pop and compare.
  task automatic cyc(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      m_edge();
      sb.push_back(m_snapshot());
      @(posedge clk);
      #1;
      cycle++;
      compare_pop(tag);
    end
  endtask

  task automatic load_ch(input int k, input int v, input string tag);
    bus.load_in[k]            = 1'b1;
    bus.divisor_in[k*W +: W]  = W'(v);
    cyc(1, tag);
    bus.load_in[k]            = 1'b0;
  endtask

  // Bounded wait until the model counter of channel k reaches target.
  task automatic wait_cnt(input int k, input int target, input string tag);
    int guard;
    guard = 0;
    while (m_cnt[k] != target && guard < 64) begin
      cyc(1, tag);
      guard++;
    end
    if (m_cnt[k] != target) chk_int({tag, ".wait_timeout"}, m_cnt[k], target);
  endtask

  int first_tick;
  int high_cnt;

  initial begin
    rst_n          = 1'b0;
    bus.enable_in  = '0;
    bus.mode_in    = '0;
    bus.load_in    = '0;
    bus.divisor_in = '0;
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
    bus.sync_in    = 1'b0;
`endif
    m_reset();

    // Reset state
    #2;
    sb.push_back(m_snapshot());
    compare_pop("reset");

    // Release between edges with both channels enabled, square mode, D=10
    bus.enable_in = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    first_tick = 0;
    high_cnt   = 0;
    for (int i = 1; i <= 25; i++) begin
      cyc(1, "default");
      if (first_tick == 0 && bus.tick_out[0]) first_tick = i;
      if (i <= 20 && bus.clock_out[0]) high_cnt++;
    end
    // Tick register rises after edge D-1, so it is high throughout cycle D
    chk_int("first_tick_edge", first_tick, 9);
    chk_int("square_high_cycles", high_cnt, 10);

    // Ch0 square D=7, ch1 tick mode D=4; loads staged until each wrap
    bus.mode_in = 2'b10;
    bus.load_in = 2'b11;
    bus.divisor_in = {W'(4), W'(7)};
    cyc(1, "load7_4");
    bus.load_in = '0;
    cyc(40, "d7_d4");

    // Ch0 back to D=10, then load 4 at counter 3: stays pending to the wrap
    load_ch(0, 10, "reload10");
    wait_cnt(0, 0, "to_wrap10");
    wait_cnt(0, 3, "to_cnt3");
    load_ch(0, 4, "load4_mid");
    chk_int("pending_after_load", int'(bus.pending_out[0]), 1);
    cyc(20, "d4_run");

    // Load 6 exactly on the wrap cycle: applied directly, never pending
    wait_cnt(0, 3, "to_last4");
    load_ch(0, 6, "load6_wrap");
    chk_int("no_pending_on_wrap_load", int'(bus.pending_out[0]), 0);
    cyc(14, "d6_run");

    // Divisors 0 and 1 clamp to 2
    load_ch(0, 0, "load0");
    cyc(10, "d0_as_2");
    load_ch(0, 1, "load1");
    cyc(10, "d1_as_2");

    // Disable mid-period with a pending divisor, then re-enable
    load_ch(0, 10, "reload10b");
    wait_cnt(0, 3, "to_cnt3b");
    load_ch(0, 5, "load5_pend");
    bus.enable_in[0] = 1'b0;
    cyc(4, "disabled");
    bus.enable_in[0] = 1'b1;
    cyc(12, "reenable_d5");

    // Asynchronous reset mid-period: outputs clear without a clock edge
    #3;
    rst_n = 1'b0;
    #1;
    m_reset();
    sb.push_back(m_snapshot());
    compare_pop("async_reset");
    #1;
    rst_n = 1'b1;
    cyc(22, "post_reset_d10");

`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
    // Both channels D=6, square mode, started two cycles apart
    bus.mode_in   = 2'b00;
    bus.enable_in = 2'b00;
    bus.load_in   = 2'b11;
    bus.divisor_in = {W'(6), W'(6)};
    cyc(1, "sync_setup");
    bus.load_in   = '0;
    bus.enable_in = 2'b01;
    cyc(2, "sync_offset");
    bus.enable_in = 2'b11;
    cyc(5, "sync_pre");
    bus.sync_in = 1'b1;
    cyc(1, "sync_pulse");
    bus.sync_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1, "sync_after");
      chk("sync_tick_aligned", {1'b0, bus.tick_out[1]}, {1'b0, bus.tick_out[0]});
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
